uart_tx: RTL
============

Name: uart_tx

Overview:
- UART transmitter; companion to the team's UART receiver; same 100 MHz fabric clock and bit timing.
- Serialises 8-bit bytes: LSB first, 1 start bit, optional parity, 1 or 2 stop bits.
- One-entry holding register in front of the shift register, so a producer can queue the next byte while the current frame is on the line.
- Back-to-back frames leave no idle gap.

Parameters:
- CLK_FREQ, 100_000_000, clock frequency in Hz.
- BAUD, 9600, line rate in bits per second; bit period UART_TICK = CLK_FREQ/BAUD cycles (integer division).
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data  input  8  byte to send; sampled only on handshake.
- valid  input  1  producer has a byte on data.
- ready  output  1  holding register empty; handshake occurs when valid && ready at a rising edge.
- tx  output  1  serial line; registered; idle high.
- busy  output  1  frame in progress or byte queued.

Behaviour:
- Reset values: tx=1, ready=1, busy=0, holding register empty, FSM in IDLE, bit timer=0, bit counter=0.
- Reset mid-frame aborts immediately; tx returns high asynchronously; queued byte is discarded.
- Handshake:
  - At an edge with valid && ready, data is copied into the holding register; ready=0 from that edge.
  - When valid=1 and ready=0, data is ignored; no side effects.
  - ready = !hold_valid, registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If hold_valid, the next edge enters START: load the shift register from hold, clear hold_valid (ready=1), drive tx=0, clear the timer.
  - Latency: handshake at edge E0 in IDLE gives tx=0 after edge E1.
  - START: tx=0 for UART_TICK cycles, then go to DATA.
  - DATA: tx = shift[0]; each bit lasts UART_TICK cycles; shift right after each bit. After 8 bits, go to PARITY if PARITY!=0, otherwise go to STOP.
  - PARITY: tx = ^byte for even, ~^byte for odd; lasts UART_TICK cycles.
  - STOP: tx=1 for STOP_BITS*UART_TICK cycles.
  - At the last cycle of STOP: if hold_valid, go directly to START (same load actions as from IDLE, no idle gap); otherwise go to IDLE.
- Bit timer: counts 0..UART_TICK-1; wraps to 0 at each bit boundary; reset to 0 on every state entry from IDLE.
- Frame length is exactly (1 + 8 + (PARITY!=0) + STOP_BITS) * UART_TICK cycles.
- busy = (state != IDLE) || hold_valid. busy falls on the edge that returns the FSM to IDLE with the holding register empty.
- Hold load vs. new handshake: no conflict, since ready=0 whenever hold is full. A handshake is possible from the edge after the load.
- tx changes only at bit boundaries; no glitches (output is a flop).

Decomposition:
- Shared package/include uart_defs:
  - CLK_FREQ default.
  - Parity encodings PAR_NONE/PAR_EVEN/PAR_ODD.
  - FSM state encodings for IDLE/START/DATA/PARITY/STOP.
  - UART_TICK derivation macro.
  - Also used by the receiver.
- One sub-module, uart_bit_timer:
  - Parameterised by UART_TICK.
  - Inputs clr, en; output tick_last (high on cycle UART_TICK-1).
  - Reusable by the receiver later.

Test Plan:
- All tests use CLK_FREQ=1_000_000, BAUD=100_000, so UART_TICK=10.
- Test 1: 0xA5, PARITY=0, STOP_BITS=1, one-cycle valid in IDLE -> tx=0 one cycle after the handshake for 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles; busy high for exactly 101 cycles after the handshake edge; ready high again 1 cycle after the handshake.
- Test 2: 0x55 then 0x0F with valid held high -> second byte accepted 2 cycles after the first; ready low until the first stop bit ends; second start bit begins the cycle immediately after the first stop bit; both frames occupy 200 contiguous cycles.
- Test 3: PARITY=1 with 0x07 -> parity bit 1. PARITY=2 with 0x07 -> parity bit 0. PARITY=2 with 0x00 -> parity bit 1. STOP_BITS=2 -> stop high 20 cycles; frame 110/120 cycles.
- Test 4: rst pulsed during the 4th data bit of 0xFF -> tx=1, ready=1, busy=0 without waiting for a clock edge. Then sending 0x3C produces a clean, correct frame.
- Test 5: valid=1 with data toggling every cycle while ready=0 -> exactly the frames of the accepted bytes appear; no extra frame; data mid-frame does not change tx.
- Test 6: receiver loopback (tx→rx) with 0x00, 0xFF, 0x5A, random x50 -> the receiver byte output matches each sent byte.

Source files
------------

// File: rtl/uart_defs.sv
// Shared UART definitions: default clock, parity encodings, FSM states, bit-period helper.
package uart_defs;

  localparam int unsigned CLK_FREQ_DEFAULT = 100_000_000;
  localparam int unsigned BAUD_DEFAULT     = 9600;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Bit period in clock cycles (integer division).
  function automatic int unsigned uart_tick(input int unsigned clk_freq,
                                            input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..UART_TICK-1 while enabled, flags the last cycle of each bit.
module uart_bit_timer #(
  parameter int unsigned UART_TICK = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick_last
);

  localparam int unsigned CW = (UART_TICK > 1) ? $clog2(UART_TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(UART_TICK - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise wrap at the bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick_last = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a start/data/parity/stop serialiser.
module uart_tx
  import uart_defs::*;
#(
  parameter int unsigned CLK_FREQ  = CLK_FREQ_DEFAULT,
  parameter int unsigned BAUD      = BAUD_DEFAULT,
  parameter int unsigned PARITY    = PAR_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned UART_TICK = uart_tick(CLK_FREQ, BAUD);
  localparam logic [2:0]  DATA_LAST = 3'd7;
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  uart_state_e state_q;
  logic [7:0]  hold_q;
  logic        hold_valid_q, hold_valid_d;
  logic [7:0]  shift_q;
  logic        par_q;
  logic [2:0]  bit_cnt_q;
  logic        tx_q, ready_q, busy_q;

  logic tick_last;
  logic accept_c, frame_end_c, load_c, go_idle_c, par_bit_c;

  // Handshake, frame-end and load decisions shared by the registers below.
  always_comb begin
    accept_c     = valid && ready_q;
    frame_end_c  = (state_q == ST_STOP) && tick_last && (bit_cnt_q == STOP_LAST);
    load_c       = hold_valid_q && ((state_q == ST_IDLE) || frame_end_c);
    go_idle_c    = !load_c && ((state_q == ST_IDLE) || frame_end_c);
    hold_valid_d = hold_valid_q;
    if (load_c)        hold_valid_d = 1'b0;
    else if (accept_c) hold_valid_d = 1'b1;
    par_bit_c    = (PARITY == PAR_ODD) ? ~^hold_q : ^hold_q;
  end

  uart_bit_timer #(
    .UART_TICK (UART_TICK)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (load_c),
    .en        (state_q != ST_IDLE),
    .tick_last (tick_last)
  );

  // Holding register: captured on handshake, emptied when the serialiser loads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      if (accept_c) hold_q <= data;
      hold_valid_q <= hold_valid_d;
      ready_q      <= !hold_valid_d;
    end
  end

  // Frame FSM with registered line output and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      busy_q <= !go_idle_c || hold_valid_d;
      if (load_c) begin
        state_q   <= ST_START;
        shift_q   <= hold_q;
        par_q     <= par_bit_c;
        bit_cnt_q <= '0;
        tx_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            tx_q <= 1'b1;
          end
          ST_START: begin
            if (tick_last) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
              tx_q      <= shift_q[0];
            end
          end
          ST_DATA: begin
            if (tick_last) begin
              if (bit_cnt_q == DATA_LAST) begin
                bit_cnt_q <= '0;
                if (PARITY != PAR_NONE) begin
                  state_q <= ST_PARITY;
                  tx_q    <= par_q;
                end else begin
                  state_q <= ST_STOP;
                  tx_q    <= 1'b1;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                shift_q   <= shift_q >> 1;
                tx_q      <= shift_q[1];
              end
            end
          end
          ST_PARITY: begin
            if (tick_last) begin
              state_q   <= ST_STOP;
              bit_cnt_q <= '0;
              tx_q      <= 1'b1;
            end
          end
          ST_STOP: begin
            if (tick_last) begin
              if (bit_cnt_q == STOP_LAST) begin
                state_q <= ST_IDLE;
                tx_q    <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ready = ready_q;
  assign tx    = tx_q;
  assign busy  = busy_q;

endmodule
